csc_fill_ctrl: RTL and testbench
================================

Name: csc_fill_ctrl

Overview:
- Sequencer that writes a MAT_RANK x MAT_RANK complex tridiagonal matrix into the csc_stor compressed-sparse-column store.
- Diagonal entries are s_val, sub-diagonal entries are a0_val and super-diagonal entries are a1_val.
- Walks columns in order and emits one column pointer per column, then that column's nonzero entries in ascending row order over a valid/ready handshake, then the final pointer.
- Sits between the parameter/config logic (supplies s, a0, a1 and start) and the storage block.

Parameters:
- MAT_RANK, 256, matrix dimension N; legal range 2 to 65536.
- IDX_W, $clog2(MAT_RANK), width of row/column indices.
- NNZ_W, $clog2(3*MAT_RANK), width of nonzero counts and column pointers.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a fill; accepted only in IDLE
- abort  in  1  cancel the current fill
- s_val_r, s_val_i  in  32 each  diagonal value (real, imag)
- a0_val_r, a0_val_i  in  32 each  sub-diagonal value, A(j+1,j)
- a1_val_r, a1_val_i  in  32 each  super-diagonal value, A(j-1,j)
- ent_vld  out  1  entry valid
- ent_rdy  in  1  storage accepts the entry
- ent_row  out  IDX_W  row index of the entry
- ent_col  out  IDX_W  column index of the entry
- ent_val_r, ent_val_i  out  32 each  entry value
- ent_last  out  1  last entry of the matrix
- cp_vld  out  1  column-pointer write strobe, single cycle, no backpressure
- cp_idx  out  IDX_W+1  pointer index, 0..N
- cp_val  out  NNZ_W  pointer value
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse on completion

Behaviour:
- Reset: all outputs 0; state IDLE; column and entry counters 0.
- Start in IDLE:
  - Latch all six value inputs.
  - busy rises the next cycle.
  - Go to CP with col=0, ptr=0.
  - start while not in IDLE is ignored.
- CP state (1 cycle):
  - cp_vld=1, cp_idx=col, cp_val=ptr.
  - Load the per-column entry sequence: super-diagonal (row col-1) if col>0, then diagonal (row col), then sub-diagonal (row col+1) if col<N-1.
  - Go to ENT.
- ENT state:
  - ent_vld=1, presenting the current entry.
  - On ent_vld&&ent_rdy: ptr+=1 and advance to the next entry of the column.
  - After the column's last entry: col+=1; go to CP if col<N, else to FIN.
  - While ent_vld&&!ent_rdy, all ent_* outputs are held stable.
- ent_last: high on row N-1 of column N-1 (the diagonal entry) only.
- FIN state (1 cycle): cp_vld=1, cp_idx=N, cp_val=ptr (=3N-2 without the optional feature). Go to DONE.
- DONE state (1 cycle): done=1, busy=0. Go to IDLE.
- Latency with ent_rdy held high: N CP cycles + (3N-2) entry cycles + 1 FIN cycle; done is asserted in cycle 4N after the start cycle.
- Abort (any state other than IDLE):
  - Next cycle: IDLE, all strobes 0, busy 0, no done pulse.
  - Abort in the same cycle as a handshake: the handshake counts at the storage side, but no further entries are emitted.
  - abort and start together in IDLE: start wins, abort is ignored.
- Column 0 has no super-diagonal entry; column N-1 has no sub-diagonal entry. N=2 gives 4 entries.
- Reset asserted mid-fill: immediate return to the reset values; the partial store contents are undefined and the store is not notified.
- Pointer arithmetic is unsigned, NNZ_W bits; overflow is impossible within the legal MAT_RANK range.

Optional Feature:
- Macro: CSC_FILL_ZERO_SKIP_EN.
- Defined:
  - An entry whose latched value has real==0 and imag==0 is not emitted and does not increment ptr.
  - Column pointers reflect only emitted entries.
  - ent_last marks the last emitted entry.
  - A column with all entries zero yields CP only.
  - If every entry is zero, the block goes straight from FIN to DONE with ent_last never asserted.
- Undefined: all 3N-2 structural entries are emitted regardless of value.

Decomposition:
- Shared package csc_pkg holds:
  - state enum (IDLE, CP, ENT, FIN, DONE);
  - entry position enum (SUP, DIAG, SUB);
  - a complex 32+32 struct;
  - IDX_W/NNZ_W helper functions, shared with csc_stor.
- Natural sub-module csc_col_seq: given col and N, produces the entry position, row index, next-position and column-end flags. It is combinational plus the position register.

Test Plan:
- N=4, s=(1,0), a0=(2,0), a1=(3,0), rdy=1:
  - cp_val sequence 0,2,5,8,10;
  - entry (row,col) order (0,0)(1,0)(0,1)(1,1)(2,1)(1,2)(2,2)(3,2)(2,3)(3,3);
  - done in cycle 16.
- Same stimulus with ent_rdy toggling pseudo-randomly: identical entry stream, ent_* stable while stalled, done delayed by exactly the number of stall cycles.
- abort asserted during column 2 of an N=8 fill: IDLE next cycle, no done; a following start produces a full clean fill.
- start pulsed during busy: ignored, stream unchanged; N=2 fill gives cp 0,2,4 and 4 entries with ent_last on (1,1).
- With CSC_FILL_ZERO_SKIP_EN, N=4 and a0=(0,0): cp 0,1,3,5,7; 7 entries with no sub-diagonal entries.
- Reset asserted mid-ENT: all outputs 0 immediately; a subsequent start behaves as from power-up.

Source files
------------

// File: rtl/csc_pkg.sv
// Shared types and width helpers for the CSC fill sequencer and the csc_stor storage block.
package csc_pkg;

   typedef enum logic [2:0] {IDLE, CP, ENT, FIN, DONE} state_e;

   typedef enum logic [1:0] {SUP, DIAG, SUB} pos_e;

   typedef struct packed {
      logic [31:0] re;
      logic [31:0] im;
   } cplx_t;

   function automatic int idx_width(input int rank);
      return (rank < 2) ? 1 : $clog2(rank);
   endfunction

   function automatic int nnz_width(input int rank);
      return $clog2(3 * rank);
   endfunction

endpackage

// File: rtl/csc_col_seq.sv
// Per-column entry walker: tracks the current tridiagonal position (SUP/DIAG/SUB) of a column
// and reports its row index, the column's first/next positions and the column-end flag.
module csc_col_seq
   import csc_pkg::*;
#(
   parameter int MAT_RANK = 256,
   parameter int IDX_W    = idx_width(MAT_RANK)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] col,
   input  logic [2:0]       pos_nz,
   input  logic             load,
   input  logic             advance,
   output pos_e             pos,
   output logic [IDX_W-1:0] row,
   output logic             col_empty,
   output logic             col_end
);

   localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(MAT_RANK - 1);

   pos_e       pos_q;
   pos_e       pos_d;
   pos_e       first_pos;
   pos_e       next_pos;
   logic [2:0] pos_en;

   // A position exists when it lies inside the matrix and its value is not being skipped.
   always_comb begin
      pos_en    = {(col != LAST_COL) & pos_nz[2], pos_nz[1], (col != '0) & pos_nz[0]};
      col_empty = ~|pos_en;
      first_pos = pos_en[0] ? SUP : (pos_en[1] ? DIAG : SUB);
      next_pos  = SUB;
      col_end   = 1'b1;
      case (pos_q)
         SUP: begin
            next_pos = pos_en[1] ? DIAG : SUB;
            col_end  = ~(pos_en[1] | pos_en[2]);
         end
         DIAG: begin
            next_pos = SUB;
            col_end  = ~pos_en[2];
         end
         default: ;
      endcase
      pos_d = pos_q;
      if (load) begin
         pos_d = first_pos;
      end else if (advance && !col_end) begin
         pos_d = next_pos;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_q <= SUP;
      end else begin
         pos_q <= pos_d;
      end
   end

   always_comb begin
      row = col;
      case (pos_q)
         SUP:     row = col - IDX_W'(1);
         SUB:     row = col + IDX_W'(1);
         default: ;
      endcase
   end

   assign pos = pos_q;

endmodule

// File: rtl/csc_fill_ctrl.sv
// Writes an N x N complex tridiagonal matrix into the CSC store, column by column.
// Define CSC_FILL_ZERO_SKIP_EN to drop entries whose latched value is exactly zero.
module csc_fill_ctrl
   import csc_pkg::*;
#(
   parameter int MAT_RANK = 256,
   parameter int IDX_W    = idx_width(MAT_RANK),
   parameter int NNZ_W    = nnz_width(MAT_RANK)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [31:0]      s_val_r,
   input  logic [31:0]      s_val_i,
   input  logic [31:0]      a0_val_r,
   input  logic [31:0]      a0_val_i,
   input  logic [31:0]      a1_val_r,
   input  logic [31:0]      a1_val_i,
   output logic             ent_vld,
   input  logic             ent_rdy,
   output logic [IDX_W-1:0] ent_row,
   output logic [IDX_W-1:0] ent_col,
   output logic [31:0]      ent_val_r,
   output logic [31:0]      ent_val_i,
   output logic             ent_last,
   output logic             cp_vld,
   output logic [IDX_W:0]   cp_idx,
   output logic [NNZ_W-1:0] cp_val,
   output logic             busy,
   output logic             done
);

   localparam logic [IDX_W-1:0] LAST_COL   = IDX_W'(MAT_RANK - 1);
   localparam logic [IDX_W-1:0] PENULT_COL = IDX_W'(MAT_RANK - 2);
   localparam logic [IDX_W:0]   CP_FINAL   = (IDX_W + 1)'(MAT_RANK);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] col_q, col_d;
   logic [NNZ_W-1:0] ptr_q, ptr_d;
   cplx_t            s_q, s_d, a0_q, a0_d, a1_q, a1_d;
   cplx_t            cur_val;
   pos_e             pos;
   logic [IDX_W-1:0] row;
   logic [2:0]       pos_nz;
   logic             col_empty, col_end, seq_load, seq_advance, tail_col;

`ifdef CSC_FILL_ZERO_SKIP_EN
   assign pos_nz = {|a0_q, |s_q, |a1_q};
`else
   assign pos_nz = 3'b111;
`endif

   // Column N-2 only ends the stream when the last column (SUP, DIAG) has nothing to emit.
   assign tail_col = (col_q == LAST_COL) ||
                     ((col_q == PENULT_COL) && !pos_nz[0] && !pos_nz[1]);

   csc_col_seq #(
      .MAT_RANK (MAT_RANK),
      .IDX_W    (IDX_W)
   ) u_col_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .col       (col_q),
      .pos_nz    (pos_nz),
      .load      (seq_load),
      .advance   (seq_advance),
      .pos       (pos),
      .row       (row),
      .col_empty (col_empty),
      .col_end   (col_end)
   );

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      ptr_d       = ptr_q;
      s_d         = s_q;
      a0_d        = a0_q;
      a1_d        = a1_q;
      seq_load    = 1'b0;
      seq_advance = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               s_d     = '{re: s_val_r, im: s_val_i};
               a0_d    = '{re: a0_val_r, im: a0_val_i};
               a1_d    = '{re: a1_val_r, im: a1_val_i};
               col_d   = '0;
               ptr_d   = '0;
               state_d = CP;
            end
         end
         CP: begin
            if (!col_empty) begin
               seq_load = 1'b1;
               state_d  = ENT;
            end else if (col_q == LAST_COL) begin
               state_d = FIN;
            end else begin
               col_d = col_q + IDX_W'(1);
            end
         end
         ENT: begin
            if (ent_rdy) begin
               seq_advance = 1'b1;
               ptr_d       = ptr_q + NNZ_W'(1);
               if (col_end) begin
                  if (col_q == LAST_COL) begin
                     state_d = FIN;
                  end else begin
                     col_d   = col_q + IDX_W'(1);
                     state_d = CP;
                  end
               end
            end
         end
         FIN:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         col_q   <= '0;
         ptr_q   <= '0;
         s_q     <= '0;
         a0_q    <= '0;
         a1_q    <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         ptr_q   <= ptr_d;
         s_q     <= s_d;
         a0_q    <= a0_d;
         a1_q    <= a1_d;
      end
   end

   // Outputs decode purely from registered state, so a stalled entry stays put.
   always_comb begin
      case (pos)
         SUP:     cur_val = a1_q;
         SUB:     cur_val = a0_q;
         default: cur_val = s_q;
      endcase
      ent_vld   = 1'b0;
      ent_row   = '0;
      ent_col   = '0;
      ent_val_r = '0;
      ent_val_i = '0;
      ent_last  = 1'b0;
      cp_vld    = 1'b0;
      cp_idx    = '0;
      cp_val    = '0;
      busy      = (state_q == CP) || (state_q == ENT) || (state_q == FIN);
      done      = (state_q == DONE);
      if (state_q == ENT) begin
         ent_vld   = 1'b1;
         ent_row   = row;
         ent_col   = col_q;
         ent_val_r = cur_val.re;
         ent_val_i = cur_val.im;
         ent_last  = col_end && tail_col;
      end
      if (state_q == CP) begin
         cp_vld = 1'b1;
         cp_idx = {1'b0, col_q};
         cp_val = ptr_q;
      end else if (state_q == FIN) begin
         cp_vld = 1'b1;
         cp_idx = CP_FINAL;
         cp_val = ptr_q;
      end
   end

endmodule

// File: tb/tb_csc_fill_ctrl.sv
// Randomized bench for csc_fill_ctrl checked against a queue model of the CSC stream.
// The model follows CSC_FILL_ZERO_SKIP_EN when it is defined.
`timescale 1ns/1ps
module tb_csc_fill_ctrl;

   localparam int N          = 4;
   localparam int IW         = $clog2(N);
   localparam int NW         = $clog2(3 * N);
   localparam int N2         = 2;
   localparam int IW2        = $clog2(N2);
   localparam int NW2        = $clog2(3 * N2);
   localparam int MAX_CYCLES = 400;

   typedef struct {
      int          row;
      int          col;
      logic [31:0] re;
      logic [31:0] im;
      bit          last;
   } ent_t;

   typedef struct {
      int idx;
      int val;
   } cp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic start, abort, ent_rdy;
   logic [31:0] s_val_r, s_val_i, a0_val_r, a0_val_i, a1_val_r, a1_val_i;
   logic ent_vld, ent_last, cp_vld, busy, done;
   logic [IW-1:0] ent_row, ent_col;
   logic [31:0] ent_val_r, ent_val_i;
   logic [IW:0] cp_idx;
   logic [NW-1:0] cp_val;

   logic start2, abort2, ent_rdy2;
   logic ent_vld2, ent_last2, cp_vld2, busy2, done2;
   logic [IW2-1:0] ent_row2, ent_col2;
   logic [31:0] ent_val_r2, ent_val_i2;
   logic [IW2:0] cp_idx2;
   logic [NW2-1:0] cp_val2;

   int checkCount;
   int errorCount;
   int expEntries;
   ent_t expEnt[$];
   cp_t expCp[$];

   always #5 clk = ~clk;

   csc_fill_ctrl #(.MAT_RANK(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .s_val_r(s_val_r), .s_val_i(s_val_i), .a0_val_r(a0_val_r), .a0_val_i(a0_val_i),
      .a1_val_r(a1_val_r), .a1_val_i(a1_val_i),
      .ent_vld(ent_vld), .ent_rdy(ent_rdy), .ent_row(ent_row), .ent_col(ent_col),
      .ent_val_r(ent_val_r), .ent_val_i(ent_val_i), .ent_last(ent_last),
      .cp_vld(cp_vld), .cp_idx(cp_idx), .cp_val(cp_val), .busy(busy), .done(done)
   );

   csc_fill_ctrl #(.MAT_RANK(N2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
      .s_val_r(s_val_r), .s_val_i(s_val_i), .a0_val_r(a0_val_r), .a0_val_i(a0_val_i),
      .a1_val_r(a1_val_r), .a1_val_i(a1_val_i),
      .ent_vld(ent_vld2), .ent_rdy(ent_rdy2), .ent_row(ent_row2), .ent_col(ent_col2),
      .ent_val_r(ent_val_r2), .ent_val_i(ent_val_i2), .ent_last(ent_last2),
      .cp_vld(cp_vld2), .cp_idx(cp_idx2), .cp_val(cp_val2), .busy(busy2), .done(done2)
   );

   // Single comparison point: every check is counted here and mismatches are reported.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_strobes"}, {59'd0, ent_vld, ent_last, cp_vld, busy, done}, 64'd0);
      checkOutput({tag, "_ent_pos"}, {ent_row, ent_col}, 64'd0);
      checkOutput({tag, "_ent_val"}, {ent_val_r, ent_val_i}, 64'd0);
      checkOutput({tag, "_cp"}, {cp_idx, cp_val}, 64'd0);
   endtask

   function automatic bit keepValue(input logic [63:0] v);
`ifdef CSC_FILL_ZERO_SKIP_EN
      return v != 64'd0;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [63:0] rndVal();
      if ($urandom_range(0, 2) == 0) return 64'd0;
      return {$urandom(), $urandom()};
   endfunction

   // Reference stream: per column a pointer, then rows col-1..col+1 that exist, then the final pointer.
   task automatic buildModel(input logic [63:0] sv, input logic [63:0] a0v, input logic [63:0] a1v);
      int   ptr;
      ent_t lastEnt;
      ptr = 0;
      expEnt.delete();
      expCp.delete();
      for (int c = 0; c < N; c++) begin
         expCp.push_back('{c, ptr});
         for (int r = c - 1; r <= c + 1; r++) begin
            logic [63:0] v;
            v = (r == c) ? sv : ((r < c) ? a1v : a0v);
            if (r >= 0 && r < N && keepValue(v)) begin
               expEnt.push_back('{r, c, v[63:32], v[31:0], 1'b0});
               ptr++;
            end
         end
      end
      expCp.push_back('{N, ptr});
      if (expEnt.size() > 0) begin
         lastEnt = expEnt.pop_back();
         lastEnt.last = 1'b1;
         expEnt.push_back(lastEnt);
      end
      expEntries = ptr;
   endtask

   // One fill on the N=4 instance; optional random backpressure, abort, stray start.
   task automatic applyStimulus(input logic [63:0] sv, input logic [63:0] a0v, input logic [63:0] a1v,
                                input bit randRdy, input int abortAt, input int startNoiseAt,
                                input bit abortWithStart);
      int   cyc;
      int   stalls;
      bit   finished;
      ent_t e;
      cp_t  p;
      buildModel(sv, a0v, a1v);
      @(negedge clk);
      checkOutput("idle_busy", {63'd0, busy}, 64'd0);
      {s_val_r, s_val_i}   = sv;
      {a0_val_r, a0_val_i} = a0v;
      {a1_val_r, a1_val_i} = a1v;
      start   = 1'b1;
      abort   = abortWithStart;
      ent_rdy = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      {s_val_r, s_val_i}   = {$urandom(), $urandom()};
      {a0_val_r, a0_val_i} = {$urandom(), $urandom()};
      {a1_val_r, a1_val_i} = {$urandom(), $urandom()};
      cyc      = 1;
      stalls   = 0;
      finished = 1'b0;
      while (!finished) begin
         ent_rdy = randRdy ? ($urandom_range(0, 2) != 0) : 1'b1;
         start   = (cyc == startNoiseAt);
         abort   = (cyc == abortAt);
         if (abortAt > 0 && cyc == abortAt + 1) begin
            checkIdle("after_abort");
            repeat (3) begin
               @(negedge clk);
               checkOutput("no_done_after_abort", {63'd0, done}, 64'd0);
            end
            finished = 1'b1;
         end else if (cyc > MAX_CYCLES) begin
            checkOutput("done_timeout", {63'd0, done}, 64'd1);
            finished = 1'b1;
         end else begin
            if (cp_vld) begin
               if (expCp.size() == 0) begin
                  checkOutput("cp_unexpected", {63'd0, cp_vld}, 64'd0);
               end else begin
                  p = expCp.pop_front();
                  checkOutput("cp_idx", cp_idx, p.idx);
                  checkOutput("cp_val", cp_val, p.val);
               end
            end
            if (ent_vld) begin
               if (expEnt.size() == 0) begin
                  checkOutput("ent_unexpected", {63'd0, ent_vld}, 64'd0);
               end else begin
                  e = expEnt[0];
                  checkOutput("ent_row", ent_row, e.row);
                  checkOutput("ent_col", ent_col, e.col);
                  checkOutput("ent_val", {ent_val_r, ent_val_i}, {e.re, e.im});
                  checkOutput("ent_last", {63'd0, ent_last}, {63'd0, e.last});
                  if (ent_rdy) e = expEnt.pop_front();
                  else stalls++;
               end
            end
            if (done) begin
               checkOutput("done_cycle", cyc, N + expEntries + stalls + 2);
               checkOutput("busy_at_done", {63'd0, busy}, 64'd0);
               checkOutput("cp_left", expCp.size(), 64'd0);
               checkOutput("ent_left", expEnt.size(), 64'd0);
               finished = 1'b1;
            end else begin
               checkOutput("busy_during_fill", {63'd0, busy}, 64'd1);
            end
         end
         if (!finished) begin
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic resetMidFill();
      @(negedge clk);
      {s_val_r, s_val_i, a0_val_r, a0_val_i, a1_val_r, a1_val_i} = {32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
      start   = 1'b1;
      ent_rdy = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("pre_reset_ent_vld", {63'd0, ent_vld}, 64'd1);
      #2 rst_n = 1'b0;
      #1 checkIdle("mid_reset");
      repeat (2) @(negedge clk);
      checkIdle("held_reset");
      rst_n = 1'b1;
      @(negedge clk);
      checkIdle("post_reset");
   endtask

   // Directed N=2 fill: cycle-by-cycle expected stream (1=pointer, 2=entry, 3=done).
   task automatic runSmall();
      int smKind[8] = '{1, 2, 2, 1, 2, 2, 1, 3};
      int smA[8]    = '{0, 0, 1, 1, 0, 1, 2, 0};
      int smB[8]    = '{0, 0, 0, 2, 1, 1, 4, 0};
      int smVal[8]  = '{0, 1, 2, 0, 3, 1, 0, 0};
      int smLast[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
      @(negedge clk);
      {s_val_r, s_val_i, a0_val_r, a0_val_i, a1_val_r, a1_val_i} = {32'd1, 32'd0, 32'd2, 32'd0, 32'd3, 32'd0};
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int c = 0; c < 8; c++) begin
         case (smKind[c])
            1: begin
               checkOutput("small_cp_vld", {63'd0, cp_vld2}, 64'd1);
               checkOutput("small_cp_idx", cp_idx2, smA[c]);
               checkOutput("small_cp_val", cp_val2, smB[c]);
            end
            2: begin
               checkOutput("small_ent_vld", {63'd0, ent_vld2}, 64'd1);
               checkOutput("small_ent_row", ent_row2, smA[c]);
               checkOutput("small_ent_col", ent_col2, smB[c]);
               checkOutput("small_ent_val", {ent_val_r2, ent_val_i2}, {32'(smVal[c]), 32'd0});
               checkOutput("small_ent_last", {63'd0, ent_last2}, smLast[c]);
            end
            default: begin
               checkOutput("small_done", {63'd0, done2}, 64'd1);
               checkOutput("small_busy_at_done", {63'd0, busy2}, 64'd0);
            end
         endcase
         @(negedge clk);
      end
   endtask

   initial begin
      logic [63:0] sv, a0v, a1v;
      checkCount = 0;
      errorCount = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      ent_rdy  = 1'b0;
      start2   = 1'b0;
      abort2   = 1'b0;
      ent_rdy2 = 1'b1;
      {s_val_r, s_val_i, a0_val_r, a0_val_i, a1_val_r, a1_val_i} = '0;
      repeat (3) @(negedge clk);
      checkIdle("reset");
      checkOutput("reset_small", {60'd0, ent_vld2, cp_vld2, busy2, done2}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      sv  = {32'd1, 32'd0};
      a0v = {32'd2, 32'd0};
      a1v = {32'd3, 32'd0};
      applyStimulus(sv, a0v, a1v, 1'b0, 0, 0, 1'b0);
      applyStimulus(sv, a0v, a1v, 1'b1, 0, 0, 1'b0);
      applyStimulus(sv, a0v, a1v, 1'b1, 0, 5, 1'b0);
      applyStimulus(sv, a0v, a1v, 1'b0, 10, 0, 1'b0);
      applyStimulus(sv, a0v, a1v, 1'b1, 0, 0, 1'b0);
      applyStimulus(sv, a0v, a1v, 1'b0, 0, 0, 1'b1);
      applyStimulus(sv, 64'd0, a1v, 1'b0, 0, 0, 1'b0);
      applyStimulus(64'd0, 64'd0, 64'd0, 1'b1, 0, 0, 1'b0);
      applyStimulus(64'd0, a0v, 64'd0, 1'b1, 0, 0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(rndVal(), rndVal(), rndVal(), 1'b1, 0, 0, 1'b0);
      end
      resetMidFill();
      applyStimulus(sv, a0v, a1v, 1'b1, 0, 0, 1'b0);
      runSmall();

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time limit reached, observed no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
